// File: rtl/viterbi_pkg.sv
// Shared types and defaults for the Viterbi datapath blocks.
package viterbi_pkg;

    // One encoder output pair.
    typedef logic [1:0] symbol_t;

    localparam int unsigned ILV_ROWS_DEF = 4;
    localparam int unsigned ILV_COLS_DEF = 8;

    // Interleaver reader states.
    typedef enum logic {
        StIdle = 1'b0,
        StRead = 1'b1
    } rd_state_e;

endpackage

// File: rtl/ilv_bank_ram.sv
// Ping-pong symbol store for the block interleaver: one write port, one registered read port.
// Contents are deliberately left unreset.
module ilv_bank_ram
    import viterbi_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [1:0]    wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [1:0]    rdata
);

    symbol_t mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/block_interleaver.sv
// Block interleaver: writes ROWS x COLS symbols row-major into one bank while the other bank
// is read out column-major. Swap ROWS and COLS to build the matching deinterleaver.
module block_interleaver
    import viterbi_pkg::*;
#(
    parameter int unsigned ROWS = ILV_ROWS_DEF,
    parameter int unsigned COLS = ILV_COLS_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_i,
    input  logic [1:0] d_in,
    output logic       valid_o,
    output logic [1:0] d_out,
    output logic       overflow_o
);

    localparam int unsigned B  = ROWS * COLS;
    localparam int unsigned AW = $clog2(B);
    localparam int unsigned RW = $clog2(ROWS);
    localparam int unsigned CW = $clog2(COLS);

    localparam logic [AW-1:0] LAST_IDX = AW'(B - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
    localparam logic [AW-1:0] STRIDE   = AW'(COLS);
    localparam logic [AW:0]   BANK_OFS = (AW + 1)'(B);

    // Writer state
    logic [AW-1:0] wr_idx_q;
    logic          wr_bank_q;
    logic [1:0]    full_q;
    logic [1:0]    full_d;
    logic          wr_en;
    logic          wr_last;
    logic [AW:0]   ram_waddr;

    // Reader state
    rd_state_e     state_q;
    rd_state_e     state_d;
    logic          rd_bank_q;
    logic [RW-1:0] rd_row_q;
    logic [RW-1:0] rd_row_d;
    logic [CW-1:0] rd_col_q;
    logic [CW-1:0] rd_col_d;
    logic [AW-1:0] rd_addr_q;
    logic [AW-1:0] rd_addr_d;
    logic          rd_issue;
    logic          rd_last;
    logic [AW:0]   ram_raddr;
    logic [1:0]    ram_rdata;
    logic          rd_vld_q;

    assign wr_en     = enable_i & ~full_q[wr_bank_q];
    assign wr_last   = wr_en & (wr_idx_q == LAST_IDX);
    assign ram_waddr = {1'b0, wr_idx_q} + (wr_bank_q ? BANK_OFS : '0);

    // A full bank under the read pointer is always drained, so a symbol is issued every
    // cycle the current read bank holds a complete block.
    assign rd_issue = (state_q == StRead) | full_q[rd_bank_q];

    // Full flags: reader release and writer completion never hit the same bank on one edge
    always_comb begin
        full_d = full_q;
        if (rd_last) begin
            full_d[rd_bank_q] = 1'b0;
        end
        if (wr_last) begin
            full_d[wr_bank_q] = 1'b1;
        end
    end

    // Writer index, bank select, full flags and sticky overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx_q   <= '0;
            wr_bank_q  <= 1'b0;
            full_q     <= '0;
            overflow_o <= 1'b0;
        end else begin
            full_q <= full_d;
            if (wr_en) begin
                wr_idx_q <= wr_last ? '0 : wr_idx_q + 1'b1;
                if (wr_last) begin
                    wr_bank_q <= ~wr_bank_q;
                end
            end else if (enable_i) begin
                overflow_o <= 1'b1;
            end
        end
    end

    // Reader FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Reader FSM next state; the other bank filling on this very edge counts as full so
    // back-to-back blocks stream without a bubble
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (rd_issue) state_d = StRead;
            StRead: if (rd_last && !full_d[~rd_bank_q]) state_d = StIdle;
        endcase
    end

    // Reader FSM outputs: end-of-block detect and bank-relative RAM read address
    always_comb begin
        rd_last   = rd_issue && (rd_row_q == LAST_ROW) && (rd_col_q == LAST_COL);
        ram_raddr = {1'b0, rd_addr_q} + (rd_bank_q ? BANK_OFS : '0);
    end

    // Column-major walk: step by COLS down a column, restart at the next column's top
    always_comb begin
        rd_row_d  = rd_row_q;
        rd_col_d  = rd_col_q;
        rd_addr_d = rd_addr_q;
        if (rd_issue) begin
            if (rd_row_q == LAST_ROW) begin
                rd_row_d = '0;
                if (rd_col_q == LAST_COL) begin
                    rd_col_d  = '0;
                    rd_addr_d = '0;
                end else begin
                    rd_col_d  = rd_col_q + 1'b1;
                    rd_addr_d = AW'(rd_col_q) + 1'b1;
                end
            end else begin
                rd_row_d  = rd_row_q + 1'b1;
                rd_addr_d = rd_addr_q + STRIDE;
            end
        end
    end

    // Reader counters and bank pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_bank_q <= 1'b0;
            rd_row_q  <= '0;
            rd_col_q  <= '0;
            rd_addr_q <= '0;
        end else begin
            rd_row_q  <= rd_row_d;
            rd_col_q  <= rd_col_d;
            rd_addr_q <= rd_addr_d;
            if (rd_last) begin
                rd_bank_q <= ~rd_bank_q;
            end
        end
    end

    // Output stage: RAM read register, then registered valid/data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld_q <= 1'b0;
            valid_o  <= 1'b0;
            d_out    <= '0;
        end else begin
            rd_vld_q <= rd_issue;
            valid_o  <= rd_vld_q;
            d_out    <= rd_vld_q ? ram_rdata : 2'b00;
        end
    end

    ilv_bank_ram #(
        .DEPTH (2 * B),
        .AW    (AW + 1)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (ram_waddr),
        .wdata (d_in),
        .re    (rd_issue),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_block_interleaver.sv
// Directed bench for block_interleaver (4x8) with a chained 8x4 deinterleaver.
module tb_block_interleaver;

    localparam int ROWS = 4;
    localparam int COLS = 8;
    localparam int B    = ROWS * COLS;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable_i = 1'b0;
    logic [1:0] d_in = 2'b00;
    logic       valid_o;
    logic [1:0] d_out;
    logic       overflow_o;
    logic       valid2;
    logic [1:0] dout2;
    logic       ovf2;

    block_interleaver #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable_i   (enable_i),
        .d_in       (d_in),
        .valid_o    (valid_o),
        .d_out      (d_out),
        .overflow_o (overflow_o)
    );

    block_interleaver #(
        .ROWS (COLS),
        .COLS (ROWS)
    ) dut_deilv (
        .clk        (clk),
        .rst        (rst),
        .enable_i   (valid_o),
        .d_in       (d_out),
        .valid_o    (valid2),
        .d_out      (dout2),
        .overflow_o (ovf2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0] outq [$];
    int         outc [$];
    logic [1:0] chq  [$];

    always @(negedge clk) begin
        if (valid_o) begin
            outq.push_back(d_out);
            outc.push_back(cyc);
        end
        if (valid2) chq.push_back(dout2);
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic send(input logic [1:0] s);
        enable_i = 1'b1;
        d_in     = s;
        @(posedge clk);
        #1;
        enable_i = 1'b0;
        d_in     = 2'b00;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_q();
        outq.delete();
        outc.delete();
        chq.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        clear_q();
    endtask

    task automatic wait_out(input int n, input int budget);
        for (int k = 0; k < budget && outq.size() < n; k++) @(posedge clk);
        idle(4);
    endtask

    // Output position p of a block carries input index (p % ROWS) * COLS + p / ROWS.
    function automatic int src_idx(input int p);
        return (p % ROWS) * COLS + p / ROWS;
    endfunction

    function automatic int outv(input int p);
        return (p < outq.size()) ? int'(outq[p]) : -1;
    endfunction

    logic [1:0] stim [256];
    int cap31;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        idle(2);
        check("reset valid_o", int'(valid_o), 0);
        check("reset d_out", int'(d_out), 0);
        check("reset overflow_o", int'(overflow_o), 0);
        rst = 1'b0;
        idle(1);

        // Single 11 at i=9 lands at output position 5
        clear_q();
        for (int i = 0; i < B; i++) send((i == 9) ? 2'b11 : 2'b00);
        wait_out(B, 100);
        check("single count", outq.size(), B);
        for (int p = 0; p < B; p++) check($sformatf("single pos %0d", p), outv(p), (p == 5) ? 3 : 0);

        // Burst at i=8,9,10 spreads to positions 1,5,9 (second bank)
        clear_q();
        for (int i = 0; i < B; i++) send((i >= 8 && i <= 10) ? 2'b11 : 2'b00);
        wait_out(B, 100);
        check("burst count", outq.size(), B);
        for (int p = 0; p < B; p++)
            check($sformatf("burst pos %0d", p), outv(p), (p == 1 || p == 5 || p == 9) ? 3 : 0);

        // Continuous 96 symbols: latency, gap-free valid, no overflow
        do_reset();
        for (int i = 0; i < 96; i++) stim[i] = 2'($urandom_range(3));
        cap31 = 0;
        for (int i = 0; i < 96; i++) begin
            send(stim[i]);
            if (i == 31) cap31 = cyc;
        end
        wait_out(96, 100);
        check("stream count", outq.size(), 96);
        check("stream first valid cycle", (outc.size() > 0) ? outc[0] : -1, cap31 + 2);
        check("stream contiguous", (outc.size() >= 96) ? outc[95] - outc[0] : -1, 95);
        check("stream overflow", int'(overflow_o), 0);
        for (int p = 0; p < 96; p++)
            check($sformatf("stream pos %0d", p), outv(p),
                  int'(stim[(p / B) * B + src_idx(p % B)]));

        // Interleave then deinterleave restores the sequence
        do_reset();
        for (int i = 0; i < 256; i++) stim[i] = 2'($urandom_range(3));
        for (int i = 0; i < 256; i++) send(stim[i]);
        for (int k = 0; k < 400 && chq.size() < 256; k++) @(posedge clk);
        idle(4);
        check("chain count", chq.size(), 256);
        for (int i = 0; i < 256; i++)
            check($sformatf("chain idx %0d", i), (i < chq.size()) ? int'(chq[i]) : -1,
                  int'(stim[i]));

        // Stalled reader: both banks fill, one more symbol is dropped
        do_reset();
        force dut.rd_issue = 1'b0;
        for (int i = 0; i < 64; i++) stim[i] = 2'($urandom_range(3));
        for (int i = 0; i < 64; i++) send(stim[i]);
        check("stall overflow before drop", int'(overflow_o), 0);
        send(2'b11);
        check("stall overflow after drop", int'(overflow_o), 1);
        check("stall no output", outq.size(), 0);
        release dut.rd_issue;
        wait_out(64, 120);
        check("stall drain count", outq.size(), 64);
        check("stall overflow sticky", int'(overflow_o), 1);
        for (int p = 0; p < 64; p++)
            check($sformatf("stall pos %0d", p), outv(p),
                  int'(stim[(p / B) * B + src_idx(p % B)]));
        rst = 1'b1;
        #1;
        check("overflow cleared by rst", int'(overflow_o), 0);
        idle(1);
        rst = 1'b0;
        clear_q();

        // Reset mid-block discards everything; next 32 symbols form block 0
        for (int i = 0; i < 52; i++) send(2'($urandom_range(3)));
        check("midrst valid before", int'(valid_o), 1);
        rst = 1'b1;
        #1;
        check("midrst valid_o", int'(valid_o), 0);
        check("midrst d_out", int'(d_out), 0);
        idle(1);
        rst = 1'b0;
        clear_q();
        for (int i = 0; i < B; i++) stim[i] = 2'($urandom_range(3));
        for (int i = 0; i < B; i++) send(stim[i]);
        wait_out(B, 100);
        idle(40);
        check("midrst count", outq.size(), B);
        for (int p = 0; p < B; p++)
            check($sformatf("midrst pos %0d", p), outv(p), int'(stim[src_idx(p)]));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/block_interleaver.md
BLOCK_INTERLEAVER -- requirements
Module: block_interleaver

Interface
REQ-001 Parameter ROWS, default 4, interleaver depth (rows per block); legal range 2..16.
REQ-002 Parameter COLS, default 8, interleaver span (columns per block); legal range 2..32.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 enable_i  input  1  d_in carries a valid encoder symbol this cycle.
REQ-006 d_in  input  2  encoder symbol (encoder d_out pair).
REQ-007 valid_o  output  1  d_out carries an interleaved symbol this cycle.
REQ-008 d_out  output  2  interleaved symbol, toward channel/decoder path.
REQ-009 overflow_o  output  1  sticky: an input symbol was dropped.

Function
REQ-010 Block size B = ROWS*COLS symbols; two B-entry banks (ping-pong); each bank has a full flag.
REQ-011 Writer: on each edge with enable_i=1 and target bank not full, store d_in at wr_idx of wr_bank (row-major), wr_idx increments.
REQ-012 When wr_idx reaches B-1 on a write: wr_idx wraps to 0, that bank's full flag sets, wr_bank toggles, all on the same edge.
REQ-013 If enable_i=1 while the target bank is full: symbol dropped, wr_idx unchanged, overflow_o set and held until reset.
REQ-014 Reader FSM states IDLE, READ; IDLE->READ on the edge where rd_bank's full flag is 1; READ->IDLE after last symbol if other bank not full, else READ continues directly on the other bank with no bubble.
REQ-015 In READ, one symbol per cycle, column-major: for c=0..COLS-1, r=0..ROWS-1, address r*COLS+c; d_out/valid_o registered.
REQ-016 Input index i=r*COLS+c appears at output position c*ROWS+r within its block.
REQ-017 On the edge that issues a bank's final symbol, its full flag clears and rd_bank toggles; a write to that bank on the same edge is blocked; writes resume the next edge.
REQ-018 Latency: valid_o for a block's first symbol is high after the second rising edge following the edge capturing its last input symbol.
REQ-019 With enable_i continuously high, overflow never occurs and valid_o, once high, stays high continuously.
REQ-020 Partial blocks are held indefinitely; no flush or timeout.
REQ-021 Deinterleaving is the same module with ROWS and COLS swapped.
REQ-022 Counters sized $clog2(B); no arithmetic wider than needed; no multipliers in address path (row/col counters, stride add).

Reset
REQ-023 rst=1 immediately forces valid_o=0, d_out=0, overflow_o=0, wr_idx=0, wr_bank=0, rd_bank=0, both full flags 0, FSM IDLE.
REQ-024 Bank memory contents are not reset.
REQ-025 Reset mid-block discards the partial block and any block being read; first symbol after release is block index 0.

Structure
REQ-026 Shared package viterbi_pkg: symbol_t (2-bit), ILV_ROWS_DEF=4, ILV_COLS_DEF=8, reader state enum.
REQ-027 One sub-module ilv_bank_ram: 2*B x 2-bit, one write port, one registered read port.

Verification
REQ-028 ROWS=4,COLS=8; 32 symbols with 2'b11 only at i=9, rest 00 -> single 2'b11 at output position 5, all others 00.
REQ-029 Burst of 2'b11 at i=8,9,10 -> 2'b11 at output positions 1,5,9 (spread by ROWS).
REQ-030 Continuous enable_i for 96 symbols -> valid_o high 96 consecutive cycles starting 2 edges after symbol 31 captured; overflow_o stays 0.
REQ-031 Chain (4,8)->(8,4) with random symbols, 256 symbols -> output equals input sequence exactly.
REQ-032 Stall reader, fill both banks, assert enable_i once more -> symbol dropped, overflow_o=1 until rst.
REQ-033 Assert rst after 20 symbols of block 1 -> valid_o=0 immediately; next 32 symbols form a clean block 0.
